// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and widths for the interconnect's masters and slaves.
package ahb3lite_pkg;

  localparam int unsigned HTRANS_SIZE = 2;
  localparam int unsigned HSIZE_SIZE  = 3;
  localparam int unsigned HBURST_SIZE = 3;
  localparam int unsigned HPROT_SIZE  = 4;

  localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [HBURST_SIZE-1:0] HBURST_SINGLE = 3'b000;

  localparam logic [HSIZE_SIZE-1:0] HSIZE_BYTE  = 3'b000;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_HWORD = 3'b001;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_WORD  = 3'b010;

  // Default command-stream widths; a master built with other widths declares the same shape locally.
  localparam int unsigned CMD_ADDR_SIZE = 32;
  localparam int unsigned CMD_DATA_SIZE = 32;

  typedef struct packed {
    logic                     write;
    logic [CMD_ADDR_SIZE-1:0] addr;
    logic [HSIZE_SIZE-1:0]    size;
    logic [CMD_DATA_SIZE-1:0] wdata;
  } ahb3lite_cmd_t;

endpackage

// File: rtl/ahb3lite_cmd_master.sv
// AHB3-Lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers
// and returns one response beat per completed data phase, in command order.
module ahb3lite_cmd_master
  import ahb3lite_pkg::*;
#(
  parameter int unsigned           HADDR_SIZE = 32,
  parameter int unsigned           HDATA_SIZE = 32,
  parameter logic [HPROT_SIZE-1:0] HPROT_VAL  = 4'b0011
) (
  input  logic                   HCLK,
  input  logic                   HRESET,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [HADDR_SIZE-1:0]  cmd_addr,
  input  logic [HSIZE_SIZE-1:0]  cmd_size,
  input  logic [HDATA_SIZE-1:0]  cmd_wdata,

  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [HDATA_SIZE-1:0]  rsp_rdata,

  output logic [HADDR_SIZE-1:0]  HADDR,
  output logic [HTRANS_SIZE-1:0] HTRANS,
  output logic                   HWRITE,
  output logic [HSIZE_SIZE-1:0]  HSIZE,
  output logic [HBURST_SIZE-1:0] HBURST,
  output logic [HPROT_SIZE-1:0]  HPROT,
  output logic                   HMASTLOCK,
  output logic [HDATA_SIZE-1:0]  HWDATA,
  input  logic [HDATA_SIZE-1:0]  HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  typedef struct packed {
    logic                  write;
    logic [HADDR_SIZE-1:0] addr;
    logic [HSIZE_SIZE-1:0] size;
    logic [HDATA_SIZE-1:0] wdata;
  } cmd_t;

  logic                  ap_valid_q, ap_valid_d;
  cmd_t                  ap_q, ap_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [HDATA_SIZE-1:0] dp_wdata_q, dp_wdata_d;
  logic                  err_hold_q, err_hold_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic dp_err, adv, accept, dp_done;

  always_comb begin
    dp_err    = dp_valid_q & (HRESP == HRESP_ERROR);
    // err_hold also blocks advance so a slave that drops ERROR early cannot promote a
    // cancelled address phase into the data phase.
    adv       = HREADY & ~dp_err & ~err_hold_q;
    cmd_ready = ~HRESET & ~err_hold_q & (~ap_valid_q | adv);
    accept    = cmd_valid & cmd_ready;
    dp_done   = dp_valid_q & HREADY;

    ap_valid_d = ap_valid_q;
    ap_d       = ap_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_wdata_d = dp_wdata_q;

    if (adv) begin
      dp_valid_d = ap_valid_q;
      dp_write_d = ap_q.write;
      dp_wdata_d = ap_q.wdata;
      ap_valid_d = 1'b0;
    end else if (dp_done) begin
      dp_valid_d = 1'b0;
    end

    if (accept) begin
      ap_valid_d = 1'b1;
      ap_d       = '{write: cmd_write, addr: cmd_addr, size: cmd_size, wdata: cmd_wdata};
    end

    err_hold_d = err_hold_q;
    if (HREADY) begin
      err_hold_d = 1'b0;
    end else if (dp_err) begin
      err_hold_d = 1'b1;
    end

    rsp_valid_d = dp_done;
    rsp_err_d   = dp_done & (HRESP == HRESP_ERROR);
    rsp_rdata_d = (dp_done & ~dp_write_q & (HRESP == HRESP_OKAY)) ? HRDATA : '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_valid_q  <= 1'b0;
      ap_q        <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      err_hold_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_q        <= ap_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      err_hold_q  <= err_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // IDLE during the second ERROR cycle cancels the pipelined address phase; AP is retained.
  assign HTRANS    = (ap_valid_q & ~err_hold_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = ap_q.addr;
  assign HWRITE    = ap_q.write;
  assign HSIZE     = ap_q.size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = dp_wdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
